// File: rtl/account_server.sv
// Bank-side account responder: sequential table scan, PIN/funds checks and
// single-edge commit of deposits, withdrawals and transfers.
module account_server #(
    parameter  int NUM_ACCTS = 3,
    parameter  int ACCT_W    = 12,
    parameter  int BAL_W     = 12,
    localparam int IDX_W     = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_we_i,
    input  logic [IDX_W-1:0]  load_idx_i,
    input  logic [ACCT_W-1:0] load_acct_i,
    input  logic [ACCT_W-1:0] load_pin_i,
    input  logic [BAL_W-1:0]  load_bal_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ACCT_W-1:0] req_acct_i,
    input  logic [ACCT_W-1:0] req_pin_i,
    input  logic [ACCT_W-1:0] req_dst_i,
    input  logic [BAL_W-1:0]  req_amount_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [2:0]        rsp_status_o,
    output logic [BAL_W-1:0]  rsp_balance_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SRC_SCAN = 3'd1,
        S_CHECK    = 3'd2,
        S_DST_SCAN = 3'd3,
        S_COMMIT   = 3'd4,
        S_RESP     = 3'd5
    } state_e;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NO_ACCT  = 3'd1;
    localparam logic [2:0] ST_BAD_PIN  = 3'd2;
    localparam logic [2:0] ST_INSUFF   = 3'd3;
    localparam logic [2:0] ST_BAD_DST  = 3'd4;
    localparam logic [2:0] ST_BAD_OP   = 3'd5;
    localparam logic [2:0] ST_OVERFLOW = 3'd6;
    localparam logic [2:0] ST_LOCKED   = 3'd7;

    localparam logic [2:0] OP_DEPOSIT  = 3'd2;
    localparam logic [2:0] OP_WITHDRAW = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, src_q, src_d, dst_q, dst_d;
    logic [2:0]          op_q;
    logic [ACCT_W-1:0]   acct_q, pin_q, dacct_q;
    logic [BAL_W-1:0]    amt_q;
    logic [ACCT_W-1:0]   tab_acct_q [NUM_ACCTS];
    logic [ACCT_W-1:0]   tab_pin_q  [NUM_ACCTS];
    logic [BAL_W-1:0]    tab_bal_q  [NUM_ACCTS];
    logic [1:0]          tab_fail_q [NUM_ACCTS];
    logic                rsp_valid_q, rsp_valid_d;
    logic [2:0]          rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]    rsp_balance_q, rsp_balance_d;

    logic [ACCT_W-1:0]   scan_acct_s;
    logic                src_hit_s, dst_hit_s, last_s, accept_s;
    logic [BAL_W-1:0]    src_bal_s, scan_bal_s, src_new_s;
    logic [BAL_W:0]      src_sum_s, dst_sum_s;
    logic [2:0]          chk_status_s;
    logic                chk_fail_s;
    logic [1:0]          fail_cnt_d;

    assign req_ready_o   = rst_ni && (state_q == S_IDLE) && !load_we_i;
    assign accept_s      = req_valid_i && req_ready_o;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_status_o  = rsp_status_q;
    assign rsp_balance_o = rsp_balance_q;

    // Scan compare and CHECK-rule evaluation; account 0 is the empty marker.
    always_comb begin
        scan_acct_s  = tab_acct_q[idx_q];
        scan_bal_s   = tab_bal_q[idx_q];
        src_bal_s    = tab_bal_q[src_q];
        src_hit_s    = (scan_acct_s != {ACCT_W{1'b0}}) && (scan_acct_s == acct_q);
        dst_hit_s    = (scan_acct_s != {ACCT_W{1'b0}}) && (scan_acct_s == dacct_q);
        last_s       = (idx_q == IDX_W'(NUM_ACCTS - 1));
        src_sum_s    = {1'b0, src_bal_s} + {1'b0, amt_q};
        dst_sum_s    = {1'b0, scan_bal_s} + {1'b0, amt_q};
        src_new_s    = (op_q == OP_DEPOSIT) ? src_sum_s[BAL_W-1:0] : (src_bal_s - amt_q);
        chk_status_s = ST_OK;
        chk_fail_s   = 1'b0;
        fail_cnt_d   = tab_fail_q[src_q];
        if (tab_fail_q[src_q] == 2'd3) begin
            chk_status_s = ST_LOCKED;
            chk_fail_s   = 1'b1;
        end else if (pin_q != tab_pin_q[src_q]) begin
            chk_status_s = ST_BAD_PIN;
            chk_fail_s   = 1'b1;
            fail_cnt_d   = tab_fail_q[src_q] + 2'd1;
        end else if (op_q > OP_TRANSFER) begin
            chk_status_s = ST_BAD_OP;
            chk_fail_s   = 1'b1;
        end else begin
            fail_cnt_d = 2'd0;
            if (((op_q == OP_WITHDRAW) || (op_q == OP_TRANSFER)) && (amt_q > src_bal_s)) begin
                chk_status_s = ST_INSUFF;
                chk_fail_s   = 1'b1;
            end else if ((op_q == OP_DEPOSIT) && src_sum_s[BAL_W]) begin
                chk_status_s = ST_OVERFLOW;
                chk_fail_s   = 1'b1;
            end else begin
                chk_status_s = ST_OK;
                chk_fail_s   = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept_s) state_d = S_SRC_SCAN; else state_d = S_IDLE;
            S_SRC_SCAN: begin
                if (src_hit_s)   state_d = S_CHECK;
                else if (last_s) state_d = S_RESP;
                else             state_d = S_SRC_SCAN;
            end
            S_CHECK: begin
                if (chk_fail_s)                                          state_d = S_RESP;
                else if ((op_q == OP_DEPOSIT) || (op_q == OP_WITHDRAW))  state_d = S_COMMIT;
                else if (op_q == OP_TRANSFER)                            state_d = S_DST_SCAN;
                else                                                     state_d = S_RESP;
            end
            S_DST_SCAN: begin
                if (dst_hit_s) begin
                    if ((idx_q == src_q) || dst_sum_s[BAL_W]) state_d = S_RESP;
                    else                                       state_d = S_COMMIT;
                end else if (last_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_DST_SCAN;
                end
            end
            S_COMMIT:   state_d = S_RESP;
            S_RESP:     if (rsp_ready_i) state_d = S_IDLE; else state_d = S_RESP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Scan index, latched entry indices and next response fields.
    always_comb begin
        idx_d         = idx_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_balance_d = rsp_balance_q;
        case (state_q)
            S_IDLE: idx_d = {IDX_W{1'b0}};
            S_SRC_SCAN: begin
                if (src_hit_s) begin
                    src_d = idx_q;
                end else if (last_s) begin
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = ST_NO_ACCT;
                    rsp_balance_d = {BAL_W{1'b0}};
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_CHECK: begin
                idx_d = {IDX_W{1'b0}};
                if (chk_fail_s) begin
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = chk_status_s;
                    rsp_balance_d = ((chk_status_s == ST_LOCKED) || (chk_status_s == ST_BAD_PIN))
                                    ? {BAL_W{1'b0}} : src_bal_s;
                end else if (op_q < OP_DEPOSIT) begin
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = ST_OK;
                    rsp_balance_d = src_bal_s;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            S_DST_SCAN: begin
                if (dst_hit_s) begin
                    if (idx_q == src_q) begin
                        rsp_valid_d   = 1'b1;
                        rsp_status_d  = ST_BAD_DST;
                        rsp_balance_d = src_bal_s;
                    end else if (dst_sum_s[BAL_W]) begin
                        rsp_valid_d   = 1'b1;
                        rsp_status_d  = ST_OVERFLOW;
                        rsp_balance_d = src_bal_s;
                    end else begin
                        dst_d = idx_q;
                    end
                end else if (last_s) begin
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = ST_BAD_DST;
                    rsp_balance_d = src_bal_s;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_COMMIT: begin
                rsp_valid_d   = 1'b1;
                rsp_status_d  = ST_OK;
                rsp_balance_d = src_new_s;
            end
            S_RESP: if (rsp_ready_i) rsp_valid_d = 1'b0; else rsp_valid_d = 1'b1;
            default: rsp_valid_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath: request latch, table provisioning/commit, response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q         <= {IDX_W{1'b0}};
            src_q         <= {IDX_W{1'b0}};
            dst_q         <= {IDX_W{1'b0}};
            op_q          <= 3'd0;
            acct_q        <= {ACCT_W{1'b0}};
            pin_q         <= {ACCT_W{1'b0}};
            dacct_q       <= {ACCT_W{1'b0}};
            amt_q         <= {BAL_W{1'b0}};
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= 3'd0;
            rsp_balance_q <= {BAL_W{1'b0}};
            for (int k = 0; k < NUM_ACCTS; k++) begin
                tab_acct_q[k] <= {ACCT_W{1'b0}};
                tab_pin_q[k]  <= {ACCT_W{1'b0}};
                tab_bal_q[k]  <= {BAL_W{1'b0}};
                tab_fail_q[k] <= 2'd0;
            end
        end else begin
            idx_q         <= idx_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_balance_q <= rsp_balance_d;
            if (accept_s) begin
                op_q    <= req_op_i;
                acct_q  <= req_acct_i;
                pin_q   <= req_pin_i;
                dacct_q <= req_dst_i;
                amt_q   <= req_amount_i;
            end
            if ((state_q == S_IDLE) && load_we_i) begin
                tab_acct_q[load_idx_i] <= load_acct_i;
                tab_pin_q[load_idx_i]  <= load_pin_i;
                tab_bal_q[load_idx_i]  <= load_bal_i;
                tab_fail_q[load_idx_i] <= 2'd0;
            end
            if (state_q == S_CHECK) begin
                tab_fail_q[src_q] <= fail_cnt_d;
            end
            // Both legs of a transfer land on this one edge.
            if (state_q == S_COMMIT) begin
                tab_bal_q[src_q] <= src_new_s;
                if (op_q == OP_TRANSFER) begin
                    tab_bal_q[dst_q] <= tab_bal_q[dst_q] + amt_q;
                end
            end
        end
    end

endmodule

// File: doc/account_server.md
# account_server

Bank-side responder for the ATM controller's account transactions. It holds a small account table of account number, PIN, balance and a lockout counter. It accepts one request at a time over a valid/ready channel and scans the table sequentially. It checks authorization and funds, commits debits and credits atomically, and returns a status and balance over a valid/ready response channel.

## Interface
- NUM_ACCTS, 3, number of table entries (≥2)
- ACCT_W, 12, account-number and PIN width
- BAL_W, 12, balance and amount width
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- load_we  in  1  write one table entry (provisioning)
- load_idx  in  $clog2(NUM_ACCTS)  entry index for load
- load_acct / load_pin  in  ACCT_W each  account number, PIN for load
- load_bal  in  BAL_W  initial balance for load
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  3  0 AUTH, 1 BALANCE, 2 DEPOSIT, 3 WITHDRAW, 4 TRANSFER
- req_acct / req_pin / req_dst  in  ACCT_W each  source account, PIN, transfer destination
- req_amount  in  BAL_W  amount for ops 2–4
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_status  out  3  0 OK, 1 NO_ACCT, 2 BAD_PIN, 3 INSUFFICIENT, 4 BAD_DST, 5 BAD_OP, 6 OVERFLOW, 7 LOCKED
- rsp_balance  out  BAL_W  source balance after the operation

## Operation
- States: IDLE, SRC_SCAN, CHECK, DST_SCAN, COMMIT, RESP.
- IDLE:
  - req_ready = (state==IDLE) && !load_we, so load has priority.
  - load_we in IDLE writes the entry and clears its fail counter. load_we outside IDLE is ignored.
- Handshake: a request is accepted when req_valid && req_ready. All req_* fields are latched at that edge and later input changes are ignored. The next state is SRC_SCAN with index 0.
- SRC_SCAN:
  - Compares one entry per cycle against the latched req_acct.
  - Account number 0 never matches; it is the reserved empty value.
  - Hit → CHECK with the source index latched. Miss on the last entry → RESP with NO_ACCT.
- CHECK evaluates in priority order, first failing rule wins:
  - fail counter == 3 → LOCKED
  - PIN mismatch → BAD_PIN, fail counter +1 (saturates at 3)
  - req_op > 4 → BAD_OP
  - PIN match → fail counter cleared
  - op 3/4 with amount > balance → INSUFFICIENT
  - op 2 with balance + amount > 2^BAL_W−1 → OVERFLOW
  - Any failure → RESP. AUTH and BALANCE → RESP with OK. Op 2/3 → COMMIT. Op 4 → DST_SCAN.
- DST_SCAN:
  - Scans like SRC_SCAN, against req_dst.
  - Miss, or a hit on the source index → RESP with BAD_DST.
  - Destination balance + amount overflow → RESP with OVERFLOW.
  - Otherwise → COMMIT.
- COMMIT writes all affected balances on a single edge, then → RESP with OK.
  - Deposit: src += amount.
  - Withdraw: src −= amount.
  - Transfer: src −= amount and dst += amount on the same edge.
- RESP:
  - rsp_valid is high; rsp_status and rsp_balance are held stable until rsp_valid && rsp_ready, then → IDLE.
  - rsp_balance = current source balance for OK, INSUFFICIENT, OVERFLOW, BAD_DST and BAD_OP.
  - rsp_balance = 0 for NO_ACCT, BAD_PIN and LOCKED.
- Amounts are unsigned. There is no wrap-around: an overflow or underflow case is rejected with the table unchanged.

## Timing
- Reset (rst low, asynchronous):
  - State → IDLE; all table entries, fail counters, rsp_valid, rsp_status and rsp_balance → 0.
  - req_ready is 0 while rst is low and 1 on the first cycle after release.
- Reset asserted mid-operation aborts it. COMMIT is a single edge, so a transfer is never half-applied.
- Let the request be accepted at edge 0, with source at index i and destination at index j. rsp_valid rises at:
  - BALANCE, AUTH, or any CHECK failure: edge i+2
  - DEPOSIT or WITHDRAW, OK: edge i+3
  - NO_ACCT: edge NUM_ACCTS
  - TRANSFER, OK: edge i+j+4
  - TRANSFER, BAD_DST on a miss: edge i+NUM_ACCTS+2
- After the response handshake edge, req_ready is 1 on the next cycle, so one idle cycle occurs between back-to-back requests.
- A response may be held indefinitely by rsp_ready=0; no new request is accepted meanwhile.

## Test plan
- Load {0x123, PIN 0x111, bal 50} at idx 0 and {0x456, PIN 0x222, bal 10} at idx 1; BALANCE on 0x456 → status 0, balance 10, rsp_valid at edge 3.
- DEPOSIT 20 to 0x123 → OK, 70; then WITHDRAW 80 → INSUFFICIENT, 70, table unchanged.
- TRANSFER 30 from 0x123 to 0x456 → OK, rsp_balance 40, rsp_valid at edge 5; a follow-up BALANCE on 0x456 returns 40. TRANSFER to 0x999 → BAD_DST; to 0x123 itself → BAD_DST.
- Three wrong PINs on 0x456 → BAD_PIN ×3; a following correct PIN → LOCKED. Reloading idx 1 clears the lock.
- Idx 1 at balance 0xFF0, DEPOSIT 0x20 → OVERFLOW, balance 0xFF0; req_op 6 with correct PIN → BAD_OP.
- Hold rsp_ready low for 5 cycles → rsp_valid and fields stable, req_ready 0. Assert rst during COMMIT of a transfer → all outputs 0, and BALANCE after reload sees the loaded values.
